// File: rtl/queen_conflict_checker.sv
// Checks whether a candidate queen is attacked by the queens already placed in rows above it.
// One shared absolute-difference unit computes the row distance, then the column distance, for each placed row.

module abs_subtractor (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] abs_diff
);
    assign abs_diff = (a >= b) ? (a - b) : (b - a);
endmodule

module queen_conflict_checker #(
    parameter int N          = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] cand_row,
    input  logic [2:0] cand_col,
    output logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic       busy,
    output logic       done,
    output logic       conflict,
    output logic [2:0] conflict_row,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, ROWD, COLD, DONE} state_t;

    localparam logic [3:0] N_L = 4'(N);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle and
    // the result outputs stay valid from that cycle until the next accepted start.
    state_t     state;
    logic [2:0] cand_row_q;
    logic [2:0] cand_col_q;
    logic [2:0] idx;
    logic [2:0] rowdiff;
    logic [2:0] sub_a;
    logic [2:0] sub_b;
    logic [2:0] abs_diff;
    logic       hit;
    logic       out_of_range;
    logic       last_row;

    always_comb begin
        sub_a = 3'd0;
        sub_b = 3'd0;
        case (state)
            ROWD: begin
                sub_a = cand_row_q;
                sub_b = idx;
            end
            COLD: begin
                sub_a = cand_col_q;
                sub_b = rd_col;
            end
            default: begin
                sub_a = 3'd0;
                sub_b = 3'd0;
            end
        endcase
    end

    abs_subtractor u_sub (
        .a        (sub_a),
        .b        (sub_b),
        .abs_diff (abs_diff)
    );

    // Same column gives a zero distance; same diagonal gives equal distances.
    assign hit          = (abs_diff == 3'd0) || (abs_diff == rowdiff);
    assign out_of_range = ({1'b0, cand_row} >= N_L) || ({1'b0, cand_col} >= N_L);
    assign last_row     = (idx == (cand_row_q - 3'd1));
    assign rd_row       = ((state == ROWD) || (state == COLD)) ? idx : 3'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cand_row_q   <= 3'd0;
            cand_col_q   <= 3'd0;
            idx          <= 3'd0;
            rowdiff      <= 3'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            conflict     <= 1'b0;
            conflict_row <= 3'd0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        cand_row_q   <= cand_row;
                        cand_col_q   <= cand_col;
                        idx          <= 3'd0;
                        conflict     <= 1'b0;
                        conflict_row <= 3'd0;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        if (out_of_range) begin
                            err      <= 1'b1;
                            conflict <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else if (cand_row == 3'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= ROWD;
                        end
                    end
                end
                ROWD: begin
                    rowdiff <= abs_diff;
                    state   <= COLD;
                end
                COLD: begin
                    if (hit && !conflict) begin
                        conflict     <= 1'b1;
                        conflict_row <= idx;
                    end
                    if ((hit && (EARLY_EXIT != 0)) || last_row) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= ROWD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_queen_conflict_checker.sv
// Directed and randomised checks of queen_conflict_checker on three parameterisations
// (N=8 early exit, N=8 full scan, N=6 early exit) sharing one board model.

module tb_queen_conflict_checker;
    logic       clk;
    logic       rst_n;
    logic [2:0] cand_row;
    logic [2:0] cand_col;
    logic       start_s        [3];
    logic [2:0] rd_row_s       [3];
    logic [2:0] rd_col_s       [3];
    logic       busy_s         [3];
    logic       done_s         [3];
    logic       conflict_s     [3];
    logic [2:0] conflict_row_s [3];
    logic       err_s          [3];

    logic [2:0] board [8];
    int         n_p  [3] = '{8, 8, 6};
    int         ee_p [3] = '{1, 0, 1};

    // {latency[7:0], conflict, conflict_row[2:0], err}
    logic [12:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) rd_col_s[i] = board[rd_row_s[i]];
    end

    queen_conflict_checker #(.N(8), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .cand_row(cand_row), .cand_col(cand_col),
        .rd_row(rd_row_s[0]), .rd_col(rd_col_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .conflict(conflict_s[0]), .conflict_row(conflict_row_s[0]), .err(err_s[0]));

    queen_conflict_checker #(.N(8), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .cand_row(cand_row), .cand_col(cand_col),
        .rd_row(rd_row_s[1]), .rd_col(rd_col_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .conflict(conflict_s[1]), .conflict_row(conflict_row_s[1]), .err(err_s[1]));

    queen_conflict_checker #(.N(6), .EARLY_EXIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .cand_row(cand_row), .cand_col(cand_col),
        .rd_row(rd_row_s[2]), .rd_col(rd_col_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .conflict(conflict_s[2]), .conflict_row(conflict_row_s[2]), .err(err_s[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] model(input int n, input int ee, input int r, input int c);
        logic [7:0] lat;
        logic       conf;
        logic [2:0] row;
        logic       e;
        int         cd;
        lat  = 8'(2 * r + 1);
        conf = 1'b0;
        row  = 3'd0;
        e    = 1'b0;
        if (r >= n || c >= n) begin
            e    = 1'b1;
            conf = 1'b1;
            lat  = 8'd1;
        end else begin
            for (int k = 0; k < r; k++) begin
                cd = (c > int'(board[k])) ? c - int'(board[k]) : int'(board[k]) - c;
                if (cd == 0 || cd == r - k) begin
                    if (!conf) begin
                        conf = 1'b1;
                        row  = 3'(k);
                    end
                    if (ee != 0) begin
                        lat = 8'(2 * k + 3);
                        break;
                    end
                end
            end
        end
        return {lat, conf, row, e};
    endfunction

    task automatic run_check(input int d, input int r, input int c, input bit poke);
        logic [12:0] e;
        int          cyc;
        bit          seen;
        exp_q.push_back(model(n_p[d], ee_p[d], r, c));
        @(negedge clk);
        cand_row   = 3'(r);
        cand_col   = 3'(c);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = poke;
        cand_row   = 3'($urandom_range(0, 7));
        cand_col   = 3'($urandom_range(0, 7));
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (done_s[d] === 1'b1) begin
                seen = 1'b1;
            end else begin
                check("busy_scan", busy_s[d], 1);
                check("rd_row_seq", rd_row_s[d], (cyc - 1) / 2);
                @(negedge clk);
                start_s[d] = 1'b0;
                cyc++;
            end
        end
        e = exp_q.pop_front();
        check("latency", cyc, e[12:5]);
        check("conflict", conflict_s[d], e[4]);
        check("conflict_row", conflict_row_s[d], e[3:1]);
        check("err", err_s[d], e[0]);
        check("busy_done", busy_s[d], 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_s[d] = 1'b0;
            check("no_extra_done", done_s[d], 0);
            check("idle_busy", busy_s[d], 0);
            check("conflict_hold", conflict_s[d], e[4]);
            check("err_hold", err_s[d], e[0]);
        end
    endtask

    initial begin
        int saw_done;
        rst_n    = 1'b0;
        cand_row = 3'd0;
        cand_col = 3'd0;
        for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
        for (int i = 0; i < 8; i++) board[i] = 3'($urandom_range(0, 7));
        board[0] = 3'd0;
        board[1] = 3'd4;
        board[2] = 3'd7;

        repeat (2) @(negedge clk);
        check("rst_busy", busy_s[0], 0);
        check("rst_done", done_s[0], 0);
        check("rst_conflict", conflict_s[0], 0);
        check("rst_conflict_row", conflict_row_s[0], 0);
        check("rst_err", err_s[0], 0);
        check("rst_rd_row", rd_row_s[0], 0);
        rst_n = 1'b1;

        run_check(0, 0, 5, 1'b0);
        run_check(0, 3, 1, 1'b0);
        run_check(0, 3, 4, 1'b0);
        run_check(1, 3, 4, 1'b0);
        run_check(0, 3, 3, 1'b0);

        // Abort a check in COLD with a one-cycle reset.
        @(negedge clk);
        cand_row   = 3'd3;
        cand_col   = 3'd1;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy_s[0], 0);
        check("abort_done", done_s[0], 0);
        check("abort_conflict", conflict_s[0], 0);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_s[0] !== 1'b0) saw_done++;
        end
        check("abort_no_done", saw_done, 0);
        run_check(0, 3, 1, 1'b0);

        run_check(2, 7, 2, 1'b1);
        run_check(2, 2, 6, 1'b0);
        run_check(0, 5, 2, 1'b1);
        run_check(1, 7, 3, 1'b1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 8; i++) board[i] = 3'($urandom_range(0, 7));
            run_check($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
